// File: rtl/store_sequencer_if.sv
// Request and memory-beat signals of the store sequencer.
// The slave modport is the sequencer's own view; master is the requester/memory side.
interface store_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ack,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_wdata, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ack,
    output req_ready, mem_valid, mem_addr, mem_we, mem_wdata, done, err
  );
endinterface

// File: rtl/store_sequencer.sv
// Store sequencer: splits a byte/half/word store at any alignment into one or
// two word-aligned memory write beats with per-lane byte enables.
module store_sequencer (
  input logic              clk,
  input logic              rst_n,
  store_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [6:0]  lane_q, lane_d;
  logic [55:0] data_q, data_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [3:0]  size_mask;
  logic [31:0] data_mask;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;

  assign accept = bus.req_valid & ready_q;

  // Bytes above the store size are cleared so idle lanes never carry stale data.
  always_comb begin
    size_mask = 4'b0000;
    data_mask = 32'h0000_0000;
    case (bus.req_size)
      2'b00: begin
        size_mask = 4'b0001;
        data_mask = 32'h0000_00FF;
      end
      2'b01: begin
        size_mask = 4'b0011;
        data_mask = 32'h0000_FFFF;
      end
      2'b10: begin
        size_mask = 4'b1111;
        data_mask = 32'hFFFF_FFFF;
      end
      default: begin
        size_mask = 4'b0000;
        data_mask = 32'h0000_0000;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.req_size == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = BEAT0;
            addr_d  = bus.req_addr[31:2];
            lane_d  = {3'b000, size_mask} << bus.req_addr[1:0];
            data_d  = {24'h00_0000, bus.req_data & data_mask} << {bus.req_addr[1:0], 3'b000};
          end
        end
      end
      BEAT0: begin
        if (bus.mem_ack) begin
          if (lane_q[6:4] != 3'b000) begin
            state_d = BEAT1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // Beat outputs come straight from held registers, so they stay put through waits.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_we    = 4'b0000;
    mem_wdata = 32'h0000_0000;
    case (state_q)
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = {addr_q, 2'b00};
        mem_we    = lane_q[3:0];
        mem_wdata = data_q[31:0];
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = {addr_q + 30'd1, 2'b00};
        mem_we    = {1'b0, lane_q[6:4]};
        mem_wdata = {8'h00, data_q[55:32]};
      end
      default: begin
        mem_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.mem_valid = mem_valid;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: directed literal scenarios plus randomized traffic,
// all checked every cycle against a byte-level model of the memory beats.
module tb_store_sequencer;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   check_en = 1'b0;
  bit   rand_ack = 1'b0;
  int   fixed_delay = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  beat_t exp_q[$];
  bit    exp_ready = 1'b0;
  bit    exp_done = 1'b0;
  bit    exp_err = 1'b0;

  store_sequencer_if bus ();

  store_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkBeat(input string name, input logic valid, input logic [31:0] addr,
                           input logic [3:0] we, input logic [31:0] wdata);
    checkOutput({name, " valid"}, 32'(bus.mem_valid), 32'(valid));
    checkOutput({name, " addr"},  bus.mem_addr, addr);
    checkOutput({name, " we"},    32'(bus.mem_we), 32'(we));
    checkOutput({name, " wdata"}, bus.mem_wdata, wdata);
  endtask

  // Model: walk the store byte by byte, placing each at its own byte address;
  // bytes landing in the word after the first one form a second beat.
  function automatic void modelStore(input logic [31:0] addr, input logic [31:0] data,
                                     input logic [1:0] size);
    beat_t       b0, b1;
    bit          second = 1'b0;
    int          nbytes;
    logic [31:0] ba;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    b0.addr  = addr & 32'hFFFF_FFFC;
    b0.we    = 4'b0000;
    b0.wdata = 32'h0;
    b1.addr  = b0.addr + 32'd4;
    b1.we    = 4'b0000;
    b1.wdata = 32'h0;
    for (int i = 0; i < nbytes; i++) begin
      ba = addr + 32'(i);
      if ((ba & 32'hFFFF_FFFC) == b0.addr) begin
        b0.we[ba[1:0]] = 1'b1;
        b0.wdata[8*ba[1:0] +: 8] = data[8*i +: 8];
      end else begin
        second = 1'b1;
        b1.we[ba[1:0]] = 1'b1;
        b1.wdata[8*ba[1:0] +: 8] = data[8*i +: 8];
      end
    end
    exp_q.push_back(b0);
    if (second) exp_q.push_back(b1);
  endfunction

  // Per-cycle comparison against the model, then advance the model one cycle.
  always @(negedge clk) begin
    bit nxt_done;
    bit nxt_err;
    if (check_en) begin
      if (!rst_n) begin
        checkOutput("rst req_ready", 32'(bus.req_ready), 32'd0);
        checkBeat("rst beat", 1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("rst done", 32'(bus.done), 32'd0);
        checkOutput("rst err", 32'(bus.err), 32'd0);
        exp_q.delete();
        exp_ready = 1'b0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
      end else begin
        checkOutput("model req_ready", 32'(bus.req_ready), 32'(exp_ready));
        checkOutput("model done", 32'(bus.done), 32'(exp_done));
        checkOutput("model err", 32'(bus.err), 32'(exp_err));
        if (exp_q.size() != 0) begin
          checkBeat("model beat", 1'b1, exp_q[0].addr, exp_q[0].we, exp_q[0].wdata);
        end else begin
          checkBeat("model idle", 1'b0, 32'h0, 4'h0, 32'h0);
        end
        nxt_done = 1'b0;
        nxt_err  = 1'b0;
        if (exp_q.size() != 0 && bus.mem_ack) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) nxt_done = 1'b1;
        end
        if (exp_ready && bus.req_valid) begin
          if (bus.req_size == 2'b11) nxt_err = 1'b1;
          else modelStore(bus.req_addr, bus.req_data, bus.req_size);
        end
        exp_done  = nxt_done;
        exp_err   = nxt_err;
        exp_ready = (exp_q.size() == 0);
      end
    end
  end

  // Memory side: ack each beat after a fixed or random number of wait cycles,
  // and toggle mem_ack randomly while idle since it must be ignored there.
  initial begin : ack_driver
    int wait_cnt;
    int cur_delay;
    wait_cnt  = 0;
    cur_delay = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_valid) begin
        if (wait_cnt == 0) cur_delay = rand_ack ? int'($urandom_range(0, 3)) : fixed_delay;
        if (wait_cnt >= cur_delay) begin
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic toDrive();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size);
    bit taken;
    taken = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_size  = size;
    for (int i = 0; i < 64 && !taken; i++) begin
      @(negedge clk);
      if (bus.req_ready) taken = 1'b1;
    end
    if (!taken) checkOutput("accept timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom();
    bus.req_data  = $urandom();
    bus.req_size  = 2'($urandom_range(0, 3));
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, tests run %0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_data  = 32'h0;
    bus.req_size  = 2'b00;
    #1 check_en = 1'b1;

    @(negedge clk);
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
    checkBeat("reset beat", 1'b0, 32'h0, 4'h0, 32'h0);
    toDrive();
    rst_n = 1'b1;

    // Aligned word, immediate ack.
    applyStimulus(32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
    @(negedge clk);
    checkBeat("word100 beat0", 1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("word100 done", 32'(bus.done), 32'd1);
    checkOutput("word100 idle valid", 32'(bus.mem_valid), 32'd0);

    // Byte in the top lane.
    toDrive();
    applyStimulus(32'h0000_0103, 32'h0000_00A5, 2'b00);
    @(negedge clk);
    checkBeat("byte103 beat0", 1'b1, 32'h0000_0100, 4'b1000, 32'hA500_0000);
    @(negedge clk);
    checkOutput("byte103 done", 32'(bus.done), 32'd1);

    // Halfword straddling a word boundary.
    toDrive();
    applyStimulus(32'h0000_0203, 32'h0000_1234, 2'b01);
    @(negedge clk);
    checkBeat("half203 beat0", 1'b1, 32'h0000_0200, 4'b1000, 32'h3400_0000);
    @(negedge clk);
    checkBeat("half203 beat1", 1'b1, 32'h0000_0204, 4'b0001, 32'h0000_0012);
    @(negedge clk);
    checkOutput("half203 done", 32'(bus.done), 32'd1);
    @(negedge clk);
    checkOutput("half203 done once", 32'(bus.done), 32'd0);

    // Misaligned word with three wait cycles per beat.
    fixed_delay = 3;
    toDrive();
    applyStimulus(32'h0000_0302, 32'h1122_3344, 2'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkBeat("word302 beat0", 1'b1, 32'h0000_0300, 4'b1100, 32'h3344_0000);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkBeat("word302 beat1", 1'b1, 32'h0000_0304, 4'b0011, 32'h0000_1122);
    end
    @(negedge clk);
    checkOutput("word302 done", 32'(bus.done), 32'd1);

    // Illegal size is rejected without any beat.
    toDrive();
    applyStimulus(32'h0000_0400, 32'h5555_AAAA, 2'b11);
    @(negedge clk);
    checkOutput("size11 err", 32'(bus.err), 32'd1);
    checkOutput("size11 no beat", 32'(bus.mem_valid), 32'd0);
    checkOutput("size11 ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    checkOutput("size11 err once", 32'(bus.err), 32'd0);

    // Word wrapping past the top of memory, reset while beat1 waits.
    toDrive();
    applyStimulus(32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkBeat("wrap beat0", 1'b1, 32'hFFFF_FFFC, 4'b1100, 32'hCCDD_0000);
    end
    @(negedge clk);
    checkBeat("wrap beat1", 1'b1, 32'h0000_0000, 4'b0011, 32'h0000_AABB);
    toDrive();
    rst_n = 1'b0;
    #1;
    checkOutput("wrap async valid", 32'(bus.mem_valid), 32'd0);
    checkOutput("wrap async we", 32'(bus.mem_we), 32'd0);
    checkOutput("wrap async ready", 32'(bus.req_ready), 32'd0);
    toDrive();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("wrap release ready low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    checkOutput("wrap release ready", 32'(bus.req_ready), 32'd1);
    checkOutput("wrap no done", 32'(bus.done), 32'd0);

    // Randomized traffic: back-to-back requests, random waits and occasional resets.
    rand_ack = 1'b1;
    toDrive();
    for (int n = 0; n < 300; n++) begin
      addr = $urandom();
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      data = $urandom();
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      applyStimulus(addr, data, size);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        #2;
        checkOutput("random async valid", 32'(bus.mem_valid), 32'd0);
        toDrive();
        rst_n = 1'b1;
      end
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) toDrive();
    end

    for (int i = 0; i < 20; i++) toDrive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
